// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - shared types and constants for the exception controller
// Purpose: state encoding, syndrome codes and default handler vector used by
//          exception_ctrl and its testbench.
// Ports:   none (package).
package exc_pkg;

  typedef enum logic [2:0] {
    RUN,
    ENTRY,
    HANDLER,
    RETURN,
    LOCKUP
  } exc_state_t;

  localparam logic [3:0] ESR_NONE  = 4'h0;
  localparam logic [3:0] ESR_IRQ   = 4'h1;
  localparam logic [3:0] ESR_UNDEF = 4'h2;
  localparam logic [3:0] ESR_LOCK  = 4'hF;

  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// rtl/exception_ctrl_irq_sync.sv - external interrupt synchronizer chain
// Purpose: STAGES-deep flop chain bringing the asynchronous interrupt level
//          into the clock domain; STAGES=0 is a combinational pass-through.
// Ports:   clk      in  clock
//          reset    in  synchronous active-high reset, clears the chain
//          irq      in  raw interrupt level
//          sync_out out synchronized interrupt level
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic sync_out
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign sync_out = irq;
    end else begin : g_chain
      logic [STAGES-1:0] chain;

      always_ff @(posedge clk) begin
        if (reset) begin
          chain <= '0;
        end else begin
          chain[0] <= irq;
          for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign sync_out = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception entry/return sequencer for the fetch PC mux
// Purpose: prioritises external IRQ and undefined-opcode traps, latches the
//          return address (elr) and syndrome (esr), redirects fetch to the
//          handler vector, masks IRQs while a handler runs and performs ERET.
// Ports:   CLOCK_50   in  clock
//          reset      in  synchronous active-high reset
//          ExtIRQ     in  external interrupt level
//          invalid_op in  decoder: current instruction undefined
//          eret       in  decoder: current instruction is ERET
//          cur_pc     in  PC of the instruction in execute
//          exc_taken  out pulse: PC mux selects exc_vector
//          exc_vector out handler entry address (constant)
//          eret_taken out pulse: PC mux selects elr
//          elr        out return address
//          esr        out syndrome code
//          in_handler out high in ENTRY and HANDLER
//          lockup     out high in LOCKUP
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          N           = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'(EXC_VECTOR_DEFAULT),
  parameter int          SYNC_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         ExtIRQ,
  input  logic         invalid_op,
  input  logic         eret,
  input  logic [N-1:0] cur_pc,
  output logic         exc_taken,
  output logic [N-1:0] exc_vector,
  output logic         eret_taken,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         in_handler,
  output logic         lockup
);

  exc_state_t state, state_nxt;
  logic       sync_out;
  logic       irq_pending;
  logic       irq_req;
  logic       take_undef;
  logic       take_irq;
  logic       go_lock;
  logic       leave_ret;

  irq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (CLOCK_50),
    .reset    (reset),
    .irq      (ExtIRQ),
    .sync_out (sync_out)
  );

  // A request that arrived while masked stays visible through irq_pending.
  assign irq_req    = irq_pending | sync_out;

  // Undefined opcode outranks the interrupt; the interrupt then stays pending.
  assign take_undef = (state == RUN) && invalid_op;
  assign take_irq   = (state == RUN) && !invalid_op && irq_req;
  assign go_lock    = (state == HANDLER) && invalid_op;
  assign leave_ret  = (state == RETURN);

  assign exc_vector = EXC_VECTOR;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (invalid_op || irq_req) state_nxt = ENTRY;
      ENTRY:   state_nxt = HANDLER;
      HANDLER: begin
        if (invalid_op) begin
          state_nxt = LOCKUP;
        end else if (eret) begin
          state_nxt = RETURN;
        end
      end
      RETURN:  state_nxt = RUN;
      LOCKUP:  state_nxt = LOCKUP;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    exc_taken  = 1'b0;
    eret_taken = 1'b0;
    in_handler = 1'b0;
    lockup     = 1'b0;
    case (state)
      ENTRY: begin
        exc_taken  = 1'b1;
        in_handler = 1'b1;
      end
      HANDLER: in_handler = 1'b1;
      RETURN:  eret_taken = 1'b1;
      LOCKUP:  lockup     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      elr         <= '0;
      esr         <= ESR_NONE;
      irq_pending <= 1'b0;
    end else begin
      if (take_undef) begin
        // Return past the faulting instruction; wraps modulo 2^N.
        elr <= cur_pc + N'(4);
        esr <= ESR_UNDEF;
      end else if (take_irq) begin
        // Interrupted instruction is flushed and re-executed on return.
        elr <= cur_pc;
        esr <= ESR_IRQ;
      end else if (go_lock) begin
        esr <= ESR_LOCK;
      end else if (leave_ret) begin
        esr <= ESR_NONE;
      end

      if (take_irq) begin
        irq_pending <= 1'b0;
      end else if (sync_out) begin
        irq_pending <= 1'b1;
      end
    end
  end

endmodule
